// File: rtl/rc_pkg.sv
// Shared constants and types for the routing-computation pipeline.
// Port order matches the router crossbar: local, east, west, north, south.
package rc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int PORT_L = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_N = 3;
    localparam int PORT_S = 4;

    localparam int RC_XY = 0;
    localparam int RC_YX = 1;
    localparam int RC_WF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rc_state_e;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input int idx);
        logic [NUM_PORTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rc_route_fn.sv
// Combinational route function: destination + congestion hints -> one-hot port.
// Out-of-mesh destinations are steered to the local port and flagged.
module rc_route_fn
    import rc_pkg::*;
#(
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0,
    parameter int COORD_W = 4,
    parameter int MESH_X  = 4,
    parameter int MESH_Y  = 4,
    parameter int ALGO    = RC_XY
) (
    input  logic [2*COORD_W-1:0]  dst_i,
    input  logic [NUM_PORTS-1:0]  congestion_i,
    output logic [NUM_PORTS-1:0]  port_o,
    output logic                  err_o
);

    localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);
    localparam logic [COORD_W:0]   MX = (COORD_W+1)'(MESH_X);
    localparam logic [COORD_W:0]   MY = (COORD_W+1)'(MESH_Y);

    logic [COORD_W-1:0] dst_x, dst_y;
    logic go_e, go_w, go_n, go_s;
    logic vert_cong;
    logic [NUM_PORTS-1:0] vert_port;
    logic unused_cong;

    assign dst_x = dst_i[2*COORD_W-1:COORD_W];
    assign dst_y = dst_i[COORD_W-1:0];

    // Unsigned compares only: the mesh has no wrap links.
    assign go_e = dst_x > CX;
    assign go_w = dst_x < CX;
    assign go_n = dst_y > CY;
    assign go_s = dst_y < CY;

    assign err_o = ({1'b0, dst_x} >= MX) || ({1'b0, dst_y} >= MY);

    assign vert_port = go_n ? port_onehot(PORT_N) : port_onehot(PORT_S);
    assign vert_cong = go_n ? congestion_i[PORT_N] : congestion_i[PORT_S];

    // Local/west hints never influence a decision.
    assign unused_cong = congestion_i[PORT_L] ^ congestion_i[PORT_W];

    always_comb begin
        port_o = port_onehot(PORT_L);
        if (!err_o) begin
            case (ALGO)
                RC_YX: begin
                    if (go_n)      port_o = port_onehot(PORT_N);
                    else if (go_s) port_o = port_onehot(PORT_S);
                    else if (go_e) port_o = port_onehot(PORT_E);
                    else if (go_w) port_o = port_onehot(PORT_W);
                end
                RC_WF: begin
                    if (go_w) begin
                        port_o = port_onehot(PORT_W);
                    end else if (go_e && (go_n || go_s)) begin
                        // Leave east only when it is congested and the vertical hop is not.
                        if (congestion_i[PORT_E] && !vert_cong) port_o = vert_port;
                        else                                    port_o = port_onehot(PORT_E);
                    end else if (go_e) begin
                        port_o = port_onehot(PORT_E);
                    end else if (go_n || go_s) begin
                        port_o = vert_port;
                    end
                end
                default: begin
                    if (go_e)      port_o = port_onehot(PORT_E);
                    else if (go_w) port_o = port_onehot(PORT_W);
                    else if (go_n) port_o = port_onehot(PORT_N);
                    else if (go_s) port_o = port_onehot(PORT_S);
                end
            endcase
        end
    end

endmodule

// File: rtl/rc_pipe.sv
// Registered routing-computation stage with a valid/ready hold register.
// A result is held until VA consumes it; consume + accept in one cycle streams back-to-back.
module rc_pipe
    import rc_pkg::*;
#(
    parameter int                CUR_X   = 0,
    parameter int                CUR_Y   = 0,
    parameter int                COORD_W = 4,
    parameter int                MESH_X  = 4,
    parameter int                MESH_Y  = 4,
    parameter int                ALGO    = RC_XY,
    parameter int                NUM_VC  = 4,
    parameter logic [NUM_VC-1:0] VC_MASK = '1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2*COORD_W-1:0]  dst,
    input  logic [NUM_PORTS-1:0]  congestion,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [NUM_PORTS-1:0]  candidateOutPort,
    output logic [NUM_VC-1:0]     candidateOutVC,
    output logic                  dst_err
);

    rc_state_e            state_q, state_d;
    logic [NUM_PORTS-1:0] port_q, port_d;
    logic                 err_q, err_d;
    logic [NUM_PORTS-1:0] route_port;
    logic                 route_err;
    logic                 accept;

    rc_route_fn #(
        .CUR_X   (CUR_X),
        .CUR_Y   (CUR_Y),
        .COORD_W (COORD_W),
        .MESH_X  (MESH_X),
        .MESH_Y  (MESH_Y),
        .ALGO    (ALGO)
    ) u_route (
        .dst_i        (dst),
        .congestion_i (congestion),
        .port_o       (route_port),
        .err_o        (route_err)
    );

    // Ready depends only on state and the consumer, never on req_valid.
    assign req_ready = (state_q == ST_IDLE) || res_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HOLD;
                    port_d  = route_port;
                    err_d   = route_err;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    port_d = route_port;
                    err_d  = route_err;
                end else if (res_ready) begin
                    state_d = ST_IDLE;
                    port_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                port_d  = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            port_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            err_q   <= err_d;
        end
    end

    assign res_valid        = (state_q == ST_HOLD);
    assign candidateOutPort = port_q;
    assign candidateOutVC   = res_valid ? VC_MASK : '0;
    assign dst_err          = err_q;

endmodule

// File: tb/tb_rc_pipe.sv
// Drives XY, YX and west-first instances (router at 1,1 in a 4x4 mesh) in lockstep
// and checks them against a one-deep scoreboard of expected results.
module tb_rc_pipe;

    localparam logic [4:0] PL = 5'b00001, PE = 5'b00010, PW = 5'b00100,
                           PN = 5'b01000, PS = 5'b10000;
    localparam logic [3:0] VCM0 = 4'hF, VCM1 = 4'hA, VCM2 = 4'h3;

    typedef struct {
        logic [4:0] p_xy;
        logic [4:0] p_yx;
        logic [4:0] p_wf;
        logic       err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req_valid = 1'b0;
    logic            res_ready = 1'b0;
    logic [7:0]      dst = '0;
    logic [4:0]      congestion = '0;
    logic [2:0]      rdy, vld, err;
    logic [2:0][4:0] port;
    logic [2:0][3:0] vc;

    exp_t sb[$];
    exp_t nxt;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rc_pipe #(.CUR_X(1), .CUR_Y(1), .COORD_W(4), .MESH_X(4), .MESH_Y(4), .ALGO(0),
              .NUM_VC(4), .VC_MASK(VCM0)) u_xy (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy[0]), .dst(dst),
        .congestion(congestion), .res_valid(vld[0]), .res_ready(res_ready),
        .candidateOutPort(port[0]), .candidateOutVC(vc[0]), .dst_err(err[0]));

    rc_pipe #(.CUR_X(1), .CUR_Y(1), .COORD_W(4), .MESH_X(4), .MESH_Y(4), .ALGO(1),
              .NUM_VC(4), .VC_MASK(VCM1)) u_yx (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy[1]), .dst(dst),
        .congestion(congestion), .res_valid(vld[1]), .res_ready(res_ready),
        .candidateOutPort(port[1]), .candidateOutVC(vc[1]), .dst_err(err[1]));

    rc_pipe #(.CUR_X(1), .CUR_Y(1), .COORD_W(4), .MESH_X(4), .MESH_Y(4), .ALGO(2),
              .NUM_VC(4), .VC_MASK(VCM2)) u_wf (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy[2]), .dst(dst),
        .congestion(congestion), .res_valid(vld[2]), .res_ready(res_ready),
        .candidateOutPort(port[2]), .candidateOutVC(vc[2]), .dst_err(err[2]));

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int i = 0; i < 3; i++) begin
            ck($sformatf("%s valid[%0d]", tag, i), 32'(vld[i]), 0);
            ck($sformatf("%s port[%0d]", tag, i), 32'(port[i]), 0);
            ck($sformatf("%s vc[%0d]", tag, i), 32'(vc[i]), 0);
            ck($sformatf("%s err[%0d]", tag, i), 32'(err[i]), 0);
        end
    endtask

    task automatic chk_res(input exp_t e);
        ck("valid xy", 32'(vld[0]), 1);
        ck("valid yx", 32'(vld[1]), 1);
        ck("valid wf", 32'(vld[2]), 1);
        ck("port xy", 32'(port[0]), 32'(e.p_xy));
        ck("port yx", 32'(port[1]), 32'(e.p_yx));
        ck("port wf", 32'(port[2]), 32'(e.p_wf));
        ck("vc xy", 32'(vc[0]), 32'(VCM0));
        ck("vc yx", 32'(vc[1]), 32'(VCM1));
        ck("vc wf", 32'(vc[2]), 32'(VCM2));
        for (int i = 0; i < 3; i++)
            ck($sformatf("dst_err[%0d]", i), 32'(err[i]), 32'(e.err));
    endtask

    // One clock: compare against the scoreboard at negedge, then update it as the DUT will.
    task automatic tick();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = (sb.size() == 0) || res_ready;
        for (int i = 0; i < 3; i++)
            ck($sformatf("req_ready[%0d]", i), 32'(rdy[i]), 32'(exp_rdy));
        if (sb.size() != 0) chk_res(sb[0]);
        else                chk_idle("idle");
        if (sb.size() != 0 && res_ready) void'(sb.pop_front());
        if (req_valid && exp_rdy) sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic [4:0] c);
        exp_t e;
        int x, y;
        x = int'(d[7:4]);
        y = int'(d[3:0]);
        e.err = (x >= 4) || (y >= 4);
        if (e.err) begin
            e.p_xy = PL; e.p_yx = PL; e.p_wf = PL;
            return e;
        end
        e.p_xy = (x > 1) ? PE : (x < 1) ? PW : (y > 1) ? PN : (y < 1) ? PS : PL;
        e.p_yx = (y > 1) ? PN : (y < 1) ? PS : (x > 1) ? PE : (x < 1) ? PW : PL;
        if (x < 1)                     e.p_wf = PW;
        else if (x > 1 && y > 1)       e.p_wf = (c[1] && !c[3]) ? PN : PE;
        else if (x > 1 && y < 1)       e.p_wf = (c[1] && !c[4]) ? PS : PE;
        else                           e.p_wf = e.p_yx;
        return e;
    endfunction

    task automatic send(input logic [7:0] d, input logic [4:0] c, input exp_t e);
        dst = d; congestion = c; req_valid = 1'b1; res_ready = 1'b1; nxt = e;
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_idle("in reset");
        rstn = 1'b1;

        // Directed routes from the router at (1,1); res_ready held high so each drains.
        send(8'h31, 5'b00000, '{PE, PE, PE, 1'b0});
        send(8'h12, 5'b00000, '{PN, PN, PN, 1'b0});
        send(8'h11, 5'b00000, '{PL, PL, PL, 1'b0});
        send(8'h33, 5'b00000, '{PE, PN, PE, 1'b0});
        send(8'h33, 5'b00010, '{PE, PN, PN, 1'b0});
        send(8'h33, 5'b01010, '{PE, PN, PE, 1'b0});
        send(8'h03, 5'b00100, '{PW, PN, PW, 1'b0});
        send(8'h30, 5'b00010, '{PE, PS, PS, 1'b0});
        send(8'h00, 5'b11111, '{PW, PS, PW, 1'b0});
        send(8'h51, 5'b00000, '{PL, PL, PL, 1'b1});
        send(8'h14, 5'b00000, '{PL, PL, PL, 1'b1});
        tick();

        // Backpressure: result must stay frozen while inputs wiggle, then stream with no gap.
        dst = 8'h32; congestion = 5'b00010; req_valid = 1'b1; res_ready = 1'b0;
        nxt = '{PE, PN, PN, 1'b0};
        tick();
        for (int i = 0; i < 3; i++) begin
            dst = 8'h03 + 8'(i); congestion = 5'(i * 7);
            tick();
        end
        dst = 8'h21; congestion = 5'b00000; res_ready = 1'b1; nxt = '{PE, PE, PE, 1'b0};
        tick();
        dst = 8'h10; nxt = '{PS, PS, PS, 1'b0};
        tick();
        req_valid = 1'b0;
        tick();
        tick();

        // Asynchronous reset while a result is held.
        dst = 8'h23; congestion = 5'b00000; req_valid = 1'b1; res_ready = 1'b0;
        nxt = '{PE, PN, PE, 1'b0};
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk_idle("async reset");
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();

        // Random stream with random backpressure, expected results from the model.
        for (int n = 0; n < 80; n++) begin
            dst        = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
            congestion = 5'($urandom);
            req_valid  = 1'($urandom_range(0, 1));
            res_ready  = 1'($urandom_range(0, 1));
            nxt        = model(dst, congestion);
            tick();
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
